// File: rtl/mhsa_fetch_ctrl_pkg.sv
// Shared types and constants for the MHSA input-fetch controller.
package mhsa_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} fetch_state_t;

  localparam int USRAM_DW = 64;

endpackage

// File: rtl/mhsa_fetch_ctrl_if.sv
// usram read port and outgoing word stream of the fetch controller.
interface mhsa_fetch_ctrl_if #(
  parameter int ADDR_W = 16
);
  import mhsa_pkg::*;

  logic                usram_rd_en;
  logic [ADDR_W-1:0]   usram_rd_addr;
  logic [USRAM_DW-1:0] usram_rdata;
  logic                m_valid;
  logic                m_ready;
  logic [USRAM_DW-1:0] m_data;
  logic                m_last;

  // Fetch controller side: issues reads, produces the stream.
  modport master (
    output usram_rd_en, usram_rd_addr,
    input  usram_rdata,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  // Memory/consumer side.
  modport slave (
    input  usram_rd_en, usram_rd_addr,
    output usram_rdata,
    input  m_valid, m_data, m_last,
    output m_ready
  );

endinterface

// File: rtl/mhsa_fetch_ctrl_fifo.sv
// First-word fall-through synchronous FIFO; head word is visible on rdata
// whenever empty is low. Push on a full FIFO is accepted only together with a pop.
module sync_fifo
  import mhsa_pkg::*;
#(
  parameter int DW    = USRAM_DW,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DW-1:0]           wdata,
  output logic [DW-1:0]           rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign count     = r_count;
  assign rdata     = r_mem[r_rptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage array; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mhsa_fetch_ctrl.sv
// Input-fetch stage: on a start[0] rising edge reads len 64-bit words from
// usram starting at input_base and streams them out with valid/ready.
// Reads are credit-limited so the output FIFO never overflows.
module mhsa_fetch_ctrl
  import mhsa_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int LEN_W    = 16,
  parameter int FIFO_DEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        start,
  input  logic [31:0]        input_base,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  mhsa_fetch_ctrl_if.master  bus
);

  localparam int CW  = $clog2(FIFO_DEP) + 1;
  localparam int CSW = CW + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              r_start_d;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  r_sent;
  logic [LEN_W-1:0]  r_len_q;
  logic              r_done;
  logic              r_inflight_p1;

  logic              w_launch;
  logic              w_rd_en;
  logic              w_pop;
  logic              w_last;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [CW-1:0]     w_fifo_count;
  logic [CSW-1:0]    w_credit;
  logic [USRAM_DW-1:0] w_fifo_rdata;
  logic              w_unused_bits;

  assign w_launch = start[0] & ~r_start_d & (r_state == IDLE);

  // Words already buffered plus the one read still in flight must stay below depth.
  assign w_credit = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight_p1};
  assign w_rd_en  = (r_state == FETCH) & (r_remaining != '0) & (w_credit < CSW'(FIFO_DEP));

  assign w_pop  = ~w_fifo_empty & bus.m_ready;
  assign w_last = ~w_fifo_empty & (r_sent == (r_len_q - 1'b1));

  assign bus.usram_rd_en   = w_rd_en;
  assign bus.usram_rd_addr = w_rd_en ? r_rd_ptr : '0;
  assign bus.m_valid       = ~w_fifo_empty;
  assign bus.m_data        = w_fifo_empty ? '0 : w_fifo_rdata;
  assign bus.m_last        = w_last;
  assign busy              = (r_state != IDLE);
  assign done              = r_done;

  assign w_unused_bits = ^{start[31:1], input_base[31:ADDR_W+3], input_base[2:0], w_fifo_full};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: zero-length jobs skip straight to FINISH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_state_nxt = (len == '0) ? FINISH : FETCH;
      FETCH:   if (w_rd_en && (r_remaining == LEN_W'(1))) w_state_nxt = DRAIN;
      DRAIN:   if (w_pop && w_last) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Job counters, start edge detect, read-latency tracking and sticky done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_d     <= 1'b0;
      r_inflight_p1 <= 1'b0;
      r_rd_ptr      <= '0;
      r_remaining   <= '0;
      r_sent        <= '0;
      r_len_q       <= '0;
      r_done        <= 1'b0;
    end else begin
      r_start_d     <= start[0];
      r_inflight_p1 <= w_rd_en;
      if (w_launch) begin
        r_rd_ptr    <= input_base[ADDR_W+2:3];
        r_remaining <= len;
        r_len_q     <= len;
        r_sent      <= '0;
        r_done      <= 1'b0;
      end else begin
        if (w_rd_en) begin
          r_rd_ptr    <= r_rd_ptr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        if (w_pop) r_sent <= r_sent + 1'b1;
        if (r_state == FINISH) r_done <= 1'b1;
      end
    end
  end

  // ---- capture stage: read data lands one cycle after the strobe ----
  sync_fifo #(
    .DW    (USRAM_DW),
    .DEPTH (FIFO_DEP)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight_p1),
    .pop   (w_pop),
    .wdata (bus.usram_rdata),
    .rdata (w_fifo_rdata),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

endmodule
